// File: rtl/ring_pkg.sv
// ring_pkg: shared types and constants for the ring decoder / checker.
//   RING_W  : width of the one-hot ring word
//   BIN_W   : width of the encoded binary index
//   state_t : lock-tracking FSM states
package ring_pkg;

    localparam int RING_W = 4;
    localparam int BIN_W  = 2;

    typedef enum logic [1:0] {
        S_UNLOCK,
        S_ACQ,
        S_LOCK
    } state_t;

endpackage

// File: rtl/ring_decoder_checker_if.sv
// ring_decoder_checker_if: bundles the ring word, its control inputs and
// the decode/status outputs of the ring checker.
//   master : producer/status side (drives ring_in, adv_en, count_clr)
//   slave  : the checker itself (drives decode and status outputs)
interface ring_decoder_checker_if #(
    parameter int ERR_W = 8
);
    import ring_pkg::*;

    logic [RING_W-1:0] ring_in;
    logic              adv_en;
    logic              count_clr;
    logic [BIN_W-1:0]  bin_out;
    logic              bin_valid;
    logic              onehot_err;
    logic              seq_err;
    logic [ERR_W-1:0]  err_count;
    logic              locked;

    modport master (
        output ring_in, adv_en, count_clr,
        input  bin_out, bin_valid, onehot_err, seq_err, err_count, locked
    );

    modport slave (
        input  ring_in, adv_en, count_clr,
        output bin_out, bin_valid, onehot_err, seq_err, err_count, locked
    );

endinterface

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: purely combinational classifier/encoder for the ring word.
//   ring_in    : sampled ring word
//   idx        : bit position of the set bit (0 when not exactly one-hot)
//   is_valid   : exactly one bit set
//   is_zero    : no bits set
//   is_illegal : two or more bits set
module onehot_to_bin
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] ring_in,
    output logic [BIN_W-1:0]  idx,
    output logic              is_valid,
    output logic              is_zero,
    output logic              is_illegal
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idx = '0;
        case (ring_in)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = '0;
        endcase
    end

    assign is_zero    = (ring_in == '0);
    assign is_valid   = $onehot(ring_in);
    assign is_illegal = !is_zero && !is_valid;

endmodule

// File: rtl/ring_decoder_checker.sv
// ring_decoder_checker: receive side of the 4-bit one-hot ring counter.
// Encodes the sampled ring word to a binary index (one clock latency) and
// tracks whether successive samples follow 0001->0010->0100->1000->0001,
// reporting lock status, one-hot violations, sequence errors and a
// saturating error count.
//   clk    : sampling clock (rising edge)
//   clearn : asynchronous active-low reset
//   bus    : slave side of ring_decoder_checker_if (ring word, adv_en,
//            count_clr in; bin_out, bin_valid, onehot_err, seq_err,
//            err_count, locked out)
module ring_decoder_checker
    import ring_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   clearn,
    ring_decoder_checker_if.slave  bus
);

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    logic [BIN_W-1:0] r_prev;
    logic [3:0]       r_match_cnt;
    logic [BIN_W-1:0] r_bin_out;
    logic             r_bin_valid;
    logic             r_onehot_err;
    logic             r_seq_err;
    logic [ERR_W-1:0] r_err_count;

    logic [BIN_W-1:0] w_idx;
    logic             w_is_valid;
    logic             w_is_zero;
    logic             w_is_illegal;
    logic [BIN_W-1:0] w_exp;
    logic [3:0]       w_match_inc;
    state_t           w_state_nxt;
    logic [BIN_W-1:0] w_prev_nxt;
    logic [3:0]       w_match_nxt;
    logic             w_onehot_nxt;
    logic             w_seq_nxt;
    logic             w_err_evt;

    onehot_to_bin u_onehot_to_bin (
        .ring_in    (bus.ring_in),
        .idx        (w_idx),
        .is_valid   (w_is_valid),
        .is_zero    (w_is_zero),
        .is_illegal (w_is_illegal)
    );

    // Expected index of this sample; the 2-bit add wraps 3 -> 0.
    assign w_exp       = bus.adv_en ? r_prev + 2'd1 : r_prev;
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_err_evt   = w_onehot_nxt || w_seq_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_match_nxt  = r_match_cnt;
        w_onehot_nxt = 1'b0;
        w_seq_nxt    = 1'b0;

        case (r_state)
            S_UNLOCK: begin
                if (w_is_valid) begin
                    w_state_nxt = S_ACQ;
                    w_prev_nxt  = w_idx;
                    w_match_nxt = '0;
                end
            end

            S_ACQ: begin
                if (w_is_valid) begin
                    w_prev_nxt = w_idx;
                    if (w_idx == w_exp) begin
                        if (w_match_inc == LOCK_TGT) begin
                            w_state_nxt = S_LOCK;
                            w_match_nxt = '0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        // A legal but out-of-order word restarts acquisition from it.
                        w_match_nxt = '0;
                    end
                end else begin
                    w_state_nxt = S_UNLOCK;
                    w_match_nxt = '0;
                end
            end

            S_LOCK: begin
                case (1'b1)
                    w_is_valid: begin
                        w_prev_nxt = w_idx;
                        if (w_idx != w_exp) begin
                            w_seq_nxt   = 1'b1;
                            w_state_nxt = S_ACQ;
                            w_match_nxt = '0;
                        end
                    end
                    w_is_illegal: begin
                        w_onehot_nxt = 1'b1;
                        w_state_nxt  = S_UNLOCK;
                    end
                    w_is_zero: begin
                        // A cleared producer is legal: drop lock silently.
                        w_state_nxt = S_UNLOCK;
                    end
                    default: w_state_nxt = S_UNLOCK;
                endcase
            end

            default: w_state_nxt = S_UNLOCK;
        endcase
    end

    // NOTE: every register, including the error counter, has an async reset so the block restarts cleanly from UNLOCK.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state      <= S_UNLOCK;
            r_prev       <= '0;
            r_match_cnt  <= '0;
            r_bin_out    <= '0;
            r_bin_valid  <= 1'b0;
            r_onehot_err <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_match_cnt  <= w_match_nxt;
            r_onehot_err <= w_onehot_nxt;
            r_seq_err    <= w_seq_nxt;
            r_bin_valid  <= w_is_valid;
            if (w_is_valid) begin
                r_bin_out <= w_idx;
            end

            // Clear wins over the old count, but a coincident error still counts once.
            if (bus.count_clr) begin
                r_err_count <= w_err_evt ? ERR_W'(1) : '0;
            end else if (w_err_evt && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.bin_out    = r_bin_out;
    assign bus.bin_valid  = r_bin_valid;
    assign bus.onehot_err = r_onehot_err;
    assign bus.seq_err    = r_seq_err;
    assign bus.err_count  = r_err_count;
    assign bus.locked     = (r_state == S_LOCK);

endmodule

// File: tb/tb_ring_decoder_checker.sv
// tb_ring_decoder_checker: table-driven bench for ring_decoder_checker.
// Main instance uses ERR_W=8; a second instance with ERR_W=2 covers
// counter saturation and clear-with-error.
module tb_ring_decoder_checker;

    typedef struct {
        logic [3:0] ring;
        logic       adv;
        logic       clr;
        logic [1:0] bin;
        logic       valid;
        logic       oh;
        logic       seq;
        logic [7:0] cnt;
        logic       lock;
    } vec_t;

    logic clk = 1'b0;
    logic clearn;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    ring_decoder_checker_if #(.ERR_W(8)) bus ();
    ring_decoder_checker_if #(.ERR_W(2)) sbus ();

    ring_decoder_checker #(.LOCK_CNT(3), .ERR_W(8)) dut (
        .clk    (clk),
        .clearn (clearn),
        .bus    (bus)
    );

    ring_decoder_checker #(.LOCK_CNT(3), .ERR_W(2)) dut_sat (
        .clk    (clk),
        .clearn (clearn),
        .bus    (sbus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] ring, input logic adv, input logic clr,
                       input logic [1:0] bin, input logic valid, input logic oh,
                       input logic seq, input logic [7:0] cnt, input logic lock);
        vec_t v;
        v.ring = ring; v.adv = adv; v.clr = clr; v.bin = bin; v.valid = valid;
        v.oh = oh; v.seq = seq; v.cnt = cnt; v.lock = lock;
        vq.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic [3:0] r, input logic a, input logic c);
        @(negedge clk);
        bus.ring_in = r; bus.adv_en = a; bus.count_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic sdrive(input logic [3:0] r, input logic a, input logic c);
        @(negedge clk);
        sbus.ring_in = r; sbus.adv_en = a; sbus.count_clr = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ring_of(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << (i % 4);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " bin_out"},    32'(bus.bin_out),    32'd0);
        check({tag, " bin_valid"},  32'(bus.bin_valid),  32'd0);
        check({tag, " onehot_err"}, 32'(bus.onehot_err), 32'd0);
        check({tag, " seq_err"},    32'(bus.seq_err),    32'd0);
        check({tag, " err_count"},  32'(bus.err_count),  32'd0);
        check({tag, " locked"},     32'(bus.locked),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int exp_cnt;

        clearn = 1'b0;
        bus.ring_in = '0;  bus.adv_en = 1'b0;  bus.count_clr = 1'b0;
        sbus.ring_in = '0; sbus.adv_en = 1'b0; sbus.count_clr = 1'b0;

        //   ring     adv   clr   bin  vld  oh   seq  cnt  lock
        // lock-up
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd0, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd0, 0);
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1, 0, 0, 8'd0, 0);
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1, 0, 0, 8'd0, 1);
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd0, 1);
        // skip while locked, then relock
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1, 0, 1, 8'd1, 0);
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1, 0, 0, 8'd1, 0);
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd1, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd1, 1);
        // illegal word in LOCK, then again in UNLOCK
        add(4'b0011, 1'b1, 1'b0, 2'd1, 0, 1, 0, 8'd2, 0);
        add(4'b0011, 1'b1, 1'b0, 2'd1, 0, 0, 0, 8'd2, 0);
        // relock ending on 0100, hold x5, then zero
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1, 0, 0, 8'd2, 0);
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd2, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd2, 0);
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1, 0, 0, 8'd2, 1);
        for (int k = 0; k < 5; k++) add(4'b0100, 1'b0, 1'b0, 2'd2, 1, 0, 0, 8'd2, 1);
        add(4'b0000, 1'b0, 1'b0, 2'd2, 0, 0, 0, 8'd2, 0);
        // clear alone
        add(4'b0000, 1'b0, 1'b1, 2'd2, 0, 0, 0, 8'd0, 0);
        // zero during ACQ discards accumulated matches
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd0, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd0, 0);
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1, 0, 0, 8'd0, 0);
        add(4'b0000, 1'b1, 1'b0, 2'd2, 0, 0, 0, 8'd0, 0);
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1, 0, 0, 8'd0, 0);
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd0, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd0, 0);
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1, 0, 0, 8'd0, 1);
        add(4'b0100, 1'b0, 1'b0, 2'd2, 1, 0, 0, 8'd0, 1);
        // seq error, then a mismatch inside ACQ restarts the match count
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 1, 8'd1, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd1, 0);
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1, 0, 0, 8'd1, 0);
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1, 0, 0, 8'd1, 0);
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1, 0, 0, 8'd1, 0);
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1, 0, 0, 8'd1, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset sat err_count", 32'(sbus.err_count), 32'd0);
        check("reset sat locked",    32'(sbus.locked),    32'd0);
        @(negedge clk);
        clearn = 1'b1;

        // Table-driven main sequence
        foreach (vq[i]) begin
            drive(vq[i].ring, vq[i].adv, vq[i].clr);
            check($sformatf("row%0d bin_out", i),    32'(bus.bin_out),    32'(vq[i].bin));
            check($sformatf("row%0d bin_valid", i),  32'(bus.bin_valid),  32'(vq[i].valid));
            check($sformatf("row%0d onehot_err", i), 32'(bus.onehot_err), 32'(vq[i].oh));
            check($sformatf("row%0d seq_err", i),    32'(bus.seq_err),    32'(vq[i].seq));
            check($sformatf("row%0d err_count", i),  32'(bus.err_count),  32'(vq[i].cnt));
            check($sformatf("row%0d locked", i),     32'(bus.locked),     32'(vq[i].lock));
        end

        // Async reset mid-lock, between clock edges
        #2;
        bus.ring_in = '0;
        clearn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        clearn = 1'b1;
        drive(4'b0001, 1'b1, 1'b0);
        check("post_rst s1 bin_out", 32'(bus.bin_out), 32'd0);
        check("post_rst s1 locked",  32'(bus.locked),  32'd0);
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0100, 1'b1, 1'b0);
        check("post_rst s3 locked",  32'(bus.locked),  32'd0);
        drive(4'b1000, 1'b1, 1'b0);
        check("post_rst s4 locked",  32'(bus.locked),  32'd1);

        // Saturation with ERR_W=2; sixth error coincides with count_clr
        p = 0;
        sdrive(ring_of(p), 1'b1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            for (int m = 0; m < 3; m++) begin
                p = (p + 1) % 4;
                sdrive(ring_of(p), 1'b1, 1'b0);
            end
            check($sformatf("sat e%0d locked", e), 32'(sbus.locked), 32'd1);
            p = (p + 2) % 4;
            sdrive(ring_of(p), 1'b1, (e == 6) ? 1'b1 : 1'b0);
            exp_cnt = (e == 6) ? 1 : ((e > 3) ? 3 : e);
            check($sformatf("sat e%0d seq_err", e),   32'(sbus.seq_err),   32'd1);
            check($sformatf("sat e%0d err_count", e), 32'(sbus.err_count), 32'(exp_cnt));
            check($sformatf("sat e%0d unlocked", e),  32'(sbus.locked),    32'd0);
        end
        sdrive(ring_of((p + 1) % 4), 1'b1, 1'b0);
        check("sat pulse end seq_err", 32'(sbus.seq_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_decoder_checker.md
Name: ring_decoder_checker

Overview:
- Receive side of the 4-bit one-hot ring counter.
- Samples the 4-bit ring word and encodes it back to a 2-bit binary index.
- Checks that successive samples follow the ring sequence 0001→0010→0100→1000→0001, and reports lock status, one-hot violations, sequence errors and a saturating error count.
- Sits beside the ring counter as a self-check / decode block feeding status logic.

Parameters:
LOCK_CNT, 3, consecutive correct transitions required to go from acquiring to locked (1..15)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock; block samples on rising edge (mid-period of the negedge-driven ring counter)
clearn  input  1  asynchronous active-low reset
ring_in  input  4  one-hot ring word from the ring counter
adv_en  input  1  1: ring expected to advance this sample; 0: ring expected to hold
count_clr  input  1  synchronous clear of err_count
bin_out  output  2  encoded index of the set bit in ring_in
bin_valid  output  1  ring_in held exactly one set bit at the last sample
onehot_err  output  1  one-cycle pulse: illegal word (≥2 bits set) seen while LOCKED
seq_err  output  1  one-cycle pulse: legal one-hot word but not the expected successor, while LOCKED
err_count  output  ERR_W  count of onehot_err + seq_err events, saturating
locked  output  1  state == LOCK

Behaviour:
- Reset (clearn=0, async):
  - State = UNLOCK; bin_out=0, bin_valid=0, onehot_err=0, seq_err=0, err_count=0, locked=0.
  - Internal prev=0, match_cnt=0.
- Sample classification (combinational on ring_in):
  - ZERO: 0000.
  - VALID: exactly one bit set; idx = bit position (0001→0, 0010→1, 0100→2, 1000→3).
  - ILLEGAL: two or more bits set.
- Encode path, latency 1 clock:
  - bin_out ← idx when VALID; bin_out holds its previous value otherwise.
  - bin_valid ← VALID.
- Expected index:
  - exp = prev+1 mod 4 (2-bit wrap, 3→0) when adv_en=1.
  - exp = prev when adv_en=0.
  - adv_en is sampled on the same edge as ring_in.
- FSM, all transitions on rising clk:
  - UNLOCK:
    - VALID → ACQ, prev=idx, match_cnt=0.
    - ZERO/ILLEGAL → stay. No errors flagged.
  - ACQ:
    - VALID and idx==exp → prev=idx, match_cnt+1. When match_cnt+1==LOCK_CNT → LOCK.
    - VALID and idx!=exp → stay, prev=idx, match_cnt=0.
    - ZERO/ILLEGAL → UNLOCK, match_cnt=0.
    - No errors flagged.
  - LOCK:
    - VALID and idx==exp → stay, prev=idx.
    - VALID and idx!=exp → seq_err=1 for one cycle, error count +1, → ACQ, prev=idx, match_cnt=0.
    - ILLEGAL → onehot_err=1 for one cycle, error count +1, → UNLOCK.
    - ZERO → UNLOCK, no error (a cleared producer is legal).
- Output timing:
  - locked, onehot_err and seq_err are registered; they change on the same edge as the state register.
- err_count:
  - Increments by 1 per error event.
  - Saturates at 2^ERR_W−1 and never wraps.
  - count_clr=1 alone → 0.
  - count_clr=1 together with an error event in the same cycle → 1.
- Reset mid-operation:
  - Immediate return to reset values regardless of state.
  - First sample after release is evaluated from UNLOCK.

Decomposition:
- Package ring_pkg:
  - Enum state_t {S_UNLOCK, S_ACQ, S_LOCK}.
  - Constants RING_W=4, BIN_W=2.
- Sub-module onehot_to_bin (purely combinational):
  - ring_in → idx, is_valid, is_zero, is_illegal.
  - Instantiated once.
- FSM, counters and output registers live in ring_decoder_checker.

Test Plan:
- Lock-up: reset, adv_en=1, feed 0001,0010,0100,1000,0001.
  - bin_out follows 0,1,2,3,0 one cycle later.
  - locked=1 after the 4th sample (3 matches).
  - err_count=0.
- Skip while LOCKED: after lock, feed 0001 then 0100.
  - seq_err pulses 1 cycle; err_count=1; locked→0 (ACQ).
  - Continuing 1000,0001,0010 relocks.
- Illegal word: in LOCK feed 0011.
  - onehot_err pulses; bin_valid=0; bin_out holds last value.
  - State UNLOCK; err_count increments.
  - Same word in UNLOCK: no pulse, no increment.
- Hold and zero: in LOCK with adv_en=0, repeat 0100 ×5 → no errors, stays locked. Then 0000 → locked=0, no error.
- Saturation/clear: ERR_W=2, force 5 seq errors.
  - err_count stops at 3.
  - count_clr coincident with a 6th error → err_count=1.
- Async reset: assert clearn=0 mid-lock between clock edges.
  - All outputs 0 immediately.
  - After release, lock needs a fresh LOCK_CNT matches.
